// File: rtl/automata_stream_ctrl_pkg.sv
// Shared types and default sizing for the automata stream controller.
// Also provides the FIFO address-width helper.
package automata_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int DEF_OFFSET_W  = 32;
  localparam int DEF_RPT_DEPTH = 8;
  localparam int DEF_CNT_W     = 16;

  function automatic int fifo_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/automata_stream_ctrl_rpt_fifo.sv
// Report FIFO: power-of-two depth, first-word-fall-through head, guarded push/pop.
// Storage is not reset; only pointers and occupancy are.
module rpt_fifo
  import automata_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_OFFSET_W,
  parameter int DEPTH = DEF_RPT_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int            AW       = fifo_addr_w(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_FULL);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      // Simultaneous push and pop leaves occupancy untouched.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/automata_stream_ctrl.sv
// Byte-stream front end for an STE matcher engine: feeds bytes, tracks offsets,
// queues match reports and flushes the engine at the end of each stream.
module automata_stream_ctrl
  import automata_stream_ctrl_pkg::*;
#(
  parameter int OFFSET_W  = DEF_OFFSET_W,
  parameter int RPT_DEPTH = DEF_RPT_DEPTH,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [7:0]          in_char,
  input  logic                in_last,
  output logic                in_ready,
  output logic [7:0]          eng_char,
  output logic                eng_step,
  output logic                eng_flush,
  input  logic                eng_result,
  output logic                rpt_valid,
  output logic [OFFSET_W-1:0] rpt_offset,
  input  logic                rpt_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    match_count
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [OFFSET_W-1:0] r_offset;
  logic [CNT_W-1:0]    r_match_cnt;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_accept;
  logic                w_push;

  // Reset gating keeps the stream stalled and the engine cleared while reset_n is low.
  assign in_ready    = reset_n && (r_state != ST_FLUSH) && !w_fifo_full;
  assign eng_flush   = !reset_n || (r_state == ST_FLUSH);
  assign w_accept    = in_valid && in_ready;
  assign eng_step    = w_accept;
  assign eng_char    = in_char;
  assign w_push      = w_accept && eng_result;
  assign rpt_valid   = !w_fifo_empty;
  assign busy        = (r_state != ST_IDLE) || rpt_valid;
  assign match_count = r_match_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = in_last ? ST_FLUSH : ST_RUN;
      ST_RUN:   if (w_accept && in_last) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The offset names the byte currently on in_char; it restarts when FLUSH ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 r_offset <= '0;
    else if (r_state == ST_FLUSH) r_offset <= '0;
    else if (w_accept)            r_offset <= r_offset + OFFSET_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                     r_match_cnt <= '0;
    else if (w_push && (r_match_cnt != {CNT_W{1'b1}})) r_match_cnt <= r_match_cnt + CNT_W'(1);
  end

  rpt_fifo #(
    .WIDTH (OFFSET_W),
    .DEPTH (RPT_DEPTH)
  ) u_rpt_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (r_offset),
    .pop       (rpt_ready),
    .pop_data  (rpt_offset),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

endmodule

// File: tb/tb_automata_stream_ctrl.sv
// Bench for automata_stream_ctrl: two instances (default widths and OFFSET_W=4/CNT_W=2)
// share one stimulus stream and are compared against a queue-based reference model.
module tb_automata_stream_ctrl;

  localparam int RPT_DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_last;
  logic        rpt_ready;
  logic        eng_result;

  logic        in_ready_a, eng_step_a, eng_flush_a, rpt_valid_a, busy_a;
  logic [7:0]  eng_char_a;
  logic [31:0] rpt_offset_a;
  logic [15:0] match_count_a;

  logic        in_ready_b, eng_step_b, eng_flush_b, rpt_valid_b, busy_b;
  logic [7:0]  eng_char_b;
  logic [3:0]  rpt_offset_b;
  logic [1:0]  match_count_b;

  always #5 clock = ~clock;

  automata_stream_ctrl u_dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_char(in_char),
    .in_last(in_last), .in_ready(in_ready_a), .eng_char(eng_char_a), .eng_step(eng_step_a),
    .eng_flush(eng_flush_a), .eng_result(eng_result), .rpt_valid(rpt_valid_a),
    .rpt_offset(rpt_offset_a), .rpt_ready(rpt_ready), .busy(busy_a), .match_count(match_count_a)
  );

  automata_stream_ctrl #(.OFFSET_W(4), .RPT_DEPTH(RPT_DEPTH), .CNT_W(2)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_char(in_char),
    .in_last(in_last), .in_ready(in_ready_b), .eng_char(eng_char_b), .eng_step(eng_step_b),
    .eng_flush(eng_flush_b), .eng_result(eng_result), .rpt_valid(rpt_valid_b),
    .rpt_offset(rpt_offset_b), .rpt_ready(rpt_ready), .busy(busy_b), .match_count(match_count_b)
  );

  // Toy engine: mode 0 reports every 'O' in a run following an 'E'; mode 1 reports odd bytes.
  int   eng_mode = 0;
  logic eng_act;

  always_comb begin
    if (eng_mode == 0) eng_result = eng_act && (eng_char_a == 8'h4F);
    else               eng_result = eng_char_a[0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        eng_act <= 1'b0;
    else if (eng_flush_a) eng_act <= 1'b0;
    else if (eng_step_a)  eng_act <= (eng_char_a == 8'h45) || eng_result;
  end

  // Reference model state.
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] q[$];
  logic [63:0] log_a[$];
  logic [63:0] log_b[$];
  longint      m_offset = 0;
  longint      m_pushes = 0;
  bit          m_flushing = 0;
  bit          m_in_stream = 0;
  bit          last_acc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic cycle(input bit v, input logic [7:0] ch, input bit last, input bit rr);
    bit exp_ready, acc, push, pop, cur_flush;
    in_valid = v; in_char = ch; in_last = last; rpt_ready = rr;
    @(negedge clock);
    exp_ready = !m_flushing && (q.size() < RPT_DEPTH);
    check("in_ready_a", in_ready_a, exp_ready);
    check("in_ready_b", in_ready_b, exp_ready);
    check("eng_step", eng_step_a, v && exp_ready);
    if (v) check("eng_char", eng_char_a, ch);
    check("eng_flush_a", eng_flush_a, m_flushing);
    check("eng_flush_b", eng_flush_b, m_flushing);
    check("rpt_valid_a", rpt_valid_a, q.size() > 0);
    check("rpt_valid_b", rpt_valid_b, q.size() > 0);
    if (q.size() > 0) begin
      check("rpt_offset_a", rpt_offset_a, {32'd0, q[0][31:0]});
      check("rpt_offset_b", rpt_offset_b, {60'd0, q[0][3:0]});
    end
    check("busy_a", busy_a, m_in_stream || m_flushing || (q.size() > 0));
    check("busy_b", busy_b, m_in_stream || m_flushing || (q.size() > 0));
    check("match_count_a", match_count_a, 64'(sat(m_pushes, 65535)));
    check("match_count_b", match_count_b, 64'(sat(m_pushes, 3)));
    acc  = v && exp_ready;
    push = acc && eng_result;
    pop  = (q.size() > 0) && rr;
    if (pop) begin
      log_a.push_back(64'(rpt_offset_a));
      log_b.push_back(64'(rpt_offset_b));
      void'(q.pop_front());
    end
    if (push) begin
      q.push_back(64'(m_offset));
      m_pushes++;
    end
    cur_flush = m_flushing;
    if (acc) begin
      m_offset++;
      if (last) begin
        m_flushing  = 1;
        m_in_stream = 0;
      end else begin
        m_in_stream = 1;
      end
    end else if (cur_flush) begin
      m_flushing = 0;
      m_offset   = 0;
    end
    last_acc = acc;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] ch, input bit last, input bit rr);
    int n;
    n = 0;
    do begin
      cycle(1'b1, ch, last, rr);
      n++;
    end while (!last_acc && n < 40);
    check("send_accepted", last_acc, 1);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rr);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b1; in_char = 8'h45; in_last = 1'b0; rpt_ready = 1'b0;
    @(negedge clock);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_eng_step", eng_step_a, 0);
    check("rst_eng_flush", eng_flush_a, 1);
    check("rst_rpt_valid_a", rpt_valid_a, 0);
    check("rst_rpt_valid_b", rpt_valid_b, 0);
    check("rst_busy", busy_a, 0);
    check("rst_match_count_a", match_count_a, 0);
    check("rst_match_count_b", match_count_b, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1; in_valid = 1'b0;
    q.delete();
    m_offset = 0; m_pushes = 0; m_flushing = 0; m_in_stream = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] romeo [7];
    int n;
    romeo = '{8'h78, 8'h52, 8'h4F, 8'h4D, 8'h45, 8'h4F, 8'h4F};
    reset_n = 1'b0; in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0; rpt_ready = 1'b0;
    do_reset();

    // "xROMEOO": reports at 5 and 6, flush right after the last byte.
    eng_mode = 0;
    log_a.delete();
    for (int i = 0; i < 7; i++) send(romeo[i], i == 6, 1'b1);
    check("romeo_flush_next", eng_flush_a, 1);
    idle(3, 1'b1);
    check("romeo_nrpt", log_a.size(), 2);
    check("romeo_rpt0", log_a[0], 5);
    check("romeo_rpt1", log_a[1], 6);
    check("romeo_count", match_count_a, 2);

    // Backpressure: eight queued reports fill the FIFO and stall input.
    eng_mode = 1;
    log_a.delete();
    for (int i = 0; i < 8; i++) send(8'h41 + 8'(2 * i), 1'b0, 1'b0);
    check("full_ready_low", in_ready_a, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h51, 1'b0, 1'b0);
    send(8'h51, 1'b1, 1'b1);
    idle(12, 1'b1);
    check("bp_nrpt", log_a.size(), 9);
    for (int i = 0; i < 9; i++) check("bp_order", log_a[i], 64'(i));

    // Occupancy 3 with simultaneous push and pop.
    log_a.delete();
    for (int i = 0; i < 3; i++) send(8'h31, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b1);
    n = 0;
    while (rpt_valid_a && n < 20) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      n++;
    end
    check("pushpop_occupancy", n, 3);
    send(8'h40, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("pushpop_nrpt", log_a.size(), 4);
    for (int i = 0; i < 4; i++) check("pushpop_order", log_a[i], 64'(i));

    // 20-byte stream, match at byte 17: narrow offset wraps to 1.
    log_a.delete(); log_b.delete();
    for (int i = 0; i < 20; i++) send((i == 17) ? 8'h21 : 8'h20, i == 19, 1'b1);
    idle(3, 1'b1);
    check("wrap_nrpt", log_b.size(), 1);
    check("wrap_off_b", log_b[0], 1);
    check("wrap_off_a", log_a[0], 17);

    // Reset mid-stream with two reports queued.
    for (int i = 0; i < 3; i++) send((i < 2) ? 8'h31 : 8'h30, 1'b0, 1'b0);
    check("pre_rst_valid", rpt_valid_a, 1);
    do_reset();
    log_a.delete();
    send(8'h43, 1'b0, 1'b1);
    idle(2, 1'b1);
    check("post_rst_nrpt", log_a.size(), 1);
    check("post_rst_off", log_a[0], 0);
    send(8'h20, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Saturation of the 2-bit match counter.
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h35, i == 4, 1'b1);
    idle(3, 1'b1);
    check("sat_count_b", match_count_b, 3);
    check("sat_count_a", match_count_a, 5);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1);
    idle(12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
